// File: rtl/arb_param_rr_prio.sv
// N-requester arbiter with runtime round-robin / fixed-priority selection.
// A grant is held until the owner releases it or the programmable hold limit expires.
module arb_param_rr_prio #(
  parameter int NUM_REQ  = 4,
  parameter int GNT_W    = $clog2(NUM_REQ),
  parameter int MAX_HOLD = 8
) (
  input  logic               arb_clk,
  input  logic               arb_rst,
  input  logic [NUM_REQ-1:0] arb_req,
  input  logic               arb_done,
  input  logic               arb_mode,
  output logic               arb_gnt_vld,
  output logic [NUM_REQ-1:0] arb_gnt_oh,
  output logic [GNT_W-1:0]   arb_gnt,
  output logic [GNT_W-1:0]   arb_ptr,
  output logic               arb_timeout
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_gnt_vld;
  logic                 w_gnt_vld_nxt;
  logic [NUM_REQ-1:0]   r_gnt_oh;
  logic [NUM_REQ-1:0]   w_gnt_oh_nxt;
  logic [GNT_W-1:0]     r_gnt;
  logic [GNT_W-1:0]     w_gnt_nxt;
  logic [GNT_W-1:0]     r_ptr;
  logic [GNT_W-1:0]     w_ptr_nxt;
  logic                 r_timeout;
  logic                 w_timeout_nxt;
  logic [7:0]           r_hold_cnt;
  logic [7:0]           w_hold_cnt_nxt;

  logic                 w_any;
  logic [GNT_W-1:0]     w_win;
  logic [GNT_W-1:0]     w_ptr_inc;
  logic                 w_rel_req;
  logic                 w_rel_done;
  logic                 w_rel_to;

  // Descending scan so the candidate closest to the search start overwrites the rest.
  always_comb begin : winner_sel
    int idx;
    w_any = |arb_req;
    w_win = '0;
    idx   = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (arb_mode) begin
        if (arb_req[GNT_W'(k)]) w_win = GNT_W'(k);
      end else begin
        idx = (int'(r_ptr) + k) % NUM_REQ;
        if (arb_req[GNT_W'(idx)]) w_win = GNT_W'(idx);
      end
    end
    w_ptr_inc = GNT_W'((int'(w_win) + 1) % NUM_REQ);
  end

  assign w_rel_req  = ~arb_req[r_gnt];
  assign w_rel_done = arb_done;
  assign w_rel_to   = (MAX_HOLD != 0) && (r_hold_cnt == 8'(MAX_HOLD - 1));

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_vld_nxt  = r_gnt_vld;
    w_gnt_oh_nxt   = r_gnt_oh;
    w_gnt_nxt      = r_gnt;
    w_ptr_nxt      = r_ptr;
    w_timeout_nxt  = 1'b0;
    w_hold_cnt_nxt = r_hold_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_state_nxt    = ST_GRANT;
          w_gnt_vld_nxt  = 1'b1;
          w_gnt_nxt      = w_win;
          w_gnt_oh_nxt   = NUM_REQ'(1) << w_win;
          w_hold_cnt_nxt = 8'd0;
          if (!arb_mode) w_ptr_nxt = w_ptr_inc;
        end
      end
      ST_GRANT: begin
        if (w_rel_req || w_rel_done || w_rel_to) begin
          // Timeout is flagged only when the limit alone forced the release.
          w_state_nxt   = ST_IDLE;
          w_gnt_vld_nxt = 1'b0;
          w_gnt_oh_nxt  = '0;
          w_gnt_nxt     = '0;
          w_timeout_nxt = w_rel_to && !w_rel_req && !w_rel_done;
        end else if (r_hold_cnt != 8'hFF) begin
          w_hold_cnt_nxt = r_hold_cnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_gnt_vld_nxt = 1'b0;
        w_gnt_oh_nxt  = '0;
        w_gnt_nxt     = '0;
      end
    endcase
  end

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      r_state    <= ST_IDLE;
      r_gnt_vld  <= 1'b0;
      r_gnt_oh   <= '0;
      r_gnt      <= '0;
      r_ptr      <= '0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= 8'd0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt_vld  <= w_gnt_vld_nxt;
      r_gnt_oh   <= w_gnt_oh_nxt;
      r_gnt      <= w_gnt_nxt;
      r_ptr      <= w_ptr_nxt;
      r_timeout  <= w_timeout_nxt;
      r_hold_cnt <= w_hold_cnt_nxt;
    end
  end

  assign arb_gnt_vld = r_gnt_vld;
  assign arb_gnt_oh  = r_gnt_oh;
  assign arb_gnt     = r_gnt;
  assign arb_ptr     = r_ptr;
  assign arb_timeout = r_timeout;

  a_gnt_onehot: assert property (@(posedge arb_clk) disable iff (arb_rst)
    (arb_gnt_vld == (|arb_gnt_oh)) && $onehot0(arb_gnt_oh));

endmodule

// File: tb/tb_arb_param_rr_prio.sv
// Bench for arb_param_rr_prio: cycle vectors on a 4-requester instance, hand-written
// sequences for pointer wrap (3-requester instance) and asynchronous reset mid-grant.
module tb_arb_param_rr_prio;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done, mode;
  logic       vld;
  logic [3:0] oh;
  logic [1:0] gnt, ptr;
  logic       to;

  logic [2:0] req3;
  logic       done3, mode3;
  logic       vld3;
  logic [2:0] oh3;
  logic [1:0] gnt3, ptr3;
  logic       to3;

  always #5 clk = ~clk;

  arb_param_rr_prio #(.NUM_REQ(4), .MAX_HOLD(4)) dut4 (
    .arb_clk(clk), .arb_rst(rst), .arb_req(req), .arb_done(done), .arb_mode(mode),
    .arb_gnt_vld(vld), .arb_gnt_oh(oh), .arb_gnt(gnt), .arb_ptr(ptr), .arb_timeout(to)
  );

  arb_param_rr_prio #(.NUM_REQ(3), .MAX_HOLD(4)) dut3 (
    .arb_clk(clk), .arb_rst(rst), .arb_req(req3), .arb_done(done3), .arb_mode(mode3),
    .arb_gnt_vld(vld3), .arb_gnt_oh(oh3), .arb_gnt(gnt3), .arb_ptr(ptr3), .arb_timeout(to3)
  );

  typedef struct {
    logic [3:0] req;
    logic       done;
    logic       mode;
    logic       e_vld;
    logic [1:0] e_gnt;
    logic [1:0] e_ptr;
    logic       e_to;
  } vec_t;

  typedef struct {
    logic       vld;
    logic [1:0] gnt;
    logic [1:0] ptr;
    logic       to;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(input logic [3:0] r, input logic d, input logic m,
                              input logic v, input logic [1:0] g, input logic [1:0] p,
                              input logic t);
    vec_t x;
    x.req = r; x.done = d; x.mode = m;
    x.e_vld = v; x.e_gnt = g; x.e_ptr = p; x.e_to = t;
    vecs.push_back(x);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check4(input exp_t e, input string tag);
    logic [3:0] eoh;
    eoh = e.vld ? (4'b0001 << e.gnt) : 4'b0000;
    chk({tag, ".vld"}, 32'(vld), 32'(e.vld));
    chk({tag, ".oh"},  32'(oh),  32'(eoh));
    chk({tag, ".gnt"}, 32'(gnt), 32'(e.gnt));
    chk({tag, ".ptr"}, 32'(ptr), 32'(e.ptr));
    chk({tag, ".to"},  32'(to),  32'(e.to));
    chk({tag, ".inv"}, 32'((vld == (|oh)) && $onehot0(oh)), 32'(1));
  endtask

  task automatic check3(input exp_t e, input string tag);
    logic [2:0] eoh;
    eoh = e.vld ? (3'b001 << e.gnt) : 3'b000;
    chk({tag, ".vld"}, 32'(vld3), 32'(e.vld));
    chk({tag, ".oh"},  32'(oh3),  32'(eoh));
    chk({tag, ".gnt"}, 32'(gnt3), 32'(e.gnt));
    chk({tag, ".ptr"}, 32'(ptr3), 32'(e.ptr));
    chk({tag, ".to"},  32'(to3),  32'(e.to));
  endtask

  task automatic step4(input vec_t v, input string tag);
    exp_t e;
    req  = v.req;
    done = v.done;
    mode = v.mode;
    e.vld = v.e_vld; e.gnt = v.e_gnt; e.ptr = v.e_ptr; e.to = v.e_to;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check4(sb.pop_front(), tag);
  endtask

  task automatic step3(input logic [2:0] r, input logic d, input logic ev,
                       input logic [1:0] eg, input logic [1:0] ep, input string tag);
    exp_t e;
    req3  = r;
    done3 = d;
    mode3 = 1'b0;
    e.vld = ev; e.gnt = eg; e.ptr = ep; e.to = 1'b0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check3(sb.pop_front(), tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

  initial begin
    exp_t z;
    vec_t v;
    z.vld = 1'b0; z.gnt = 2'd0; z.ptr = 2'd0; z.to = 1'b0;

    rst = 1'b1; req = '0; done = 1'b0; mode = 1'b0;
    req3 = '0; done3 = 1'b0; mode3 = 1'b0;

    // req, done, mode | vld, gnt, ptr, timeout
    // Round-robin fairness with all four requesting.
    add(4'hF, 0, 0, 1, 2'd0, 2'd1, 0);
    add(4'hF, 1, 0, 0, 2'd0, 2'd1, 0);
    add(4'hF, 0, 0, 1, 2'd1, 2'd2, 0);
    add(4'hF, 1, 0, 0, 2'd0, 2'd2, 0);
    add(4'hF, 0, 0, 1, 2'd2, 2'd3, 0);
    add(4'hF, 1, 0, 0, 2'd0, 2'd3, 0);
    add(4'hF, 0, 0, 1, 2'd3, 2'd0, 0);
    add(4'hF, 1, 0, 0, 2'd0, 2'd0, 0);
    add(4'hF, 0, 0, 1, 2'd0, 2'd1, 0);
    add(4'hF, 1, 0, 0, 2'd0, 2'd1, 0);
    add(4'h0, 0, 0, 0, 2'd0, 2'd1, 0);
    // Fixed priority, pointer untouched.
    add(4'hA, 0, 1, 1, 2'd1, 2'd1, 0);
    add(4'hA, 1, 1, 0, 2'd0, 2'd1, 0);
    add(4'hA, 0, 1, 1, 2'd1, 2'd1, 0);
    add(4'hA, 1, 1, 0, 2'd0, 2'd1, 0);
    add(4'hA, 0, 1, 1, 2'd1, 2'd1, 0);
    add(4'hA, 1, 1, 0, 2'd0, 2'd1, 0);
    add(4'h0, 0, 1, 0, 2'd0, 2'd1, 0);
    // Hold timeout: four grant cycles then a one-cycle timeout pulse.
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 0, 1, 0, 2'd0, 2'd1, 1);
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h0, 0, 1, 0, 2'd0, 2'd1, 0);
    add(4'h0, 0, 1, 0, 2'd0, 2'd1, 0);
    // Done coincident with the limit: normal release, no pulse.
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 0, 1, 1, 2'd0, 2'd1, 0);
    add(4'h1, 1, 1, 0, 2'd0, 2'd1, 0);
    add(4'h0, 0, 1, 0, 2'd0, 2'd1, 0);
    // Mode switch during a grant to 2 affects only the next arbitration.
    add(4'h7, 0, 0, 1, 2'd1, 2'd2, 0);
    add(4'h7, 1, 0, 0, 2'd0, 2'd2, 0);
    add(4'h7, 0, 0, 1, 2'd2, 2'd3, 0);
    add(4'h7, 0, 1, 1, 2'd2, 2'd3, 0);
    add(4'h7, 1, 1, 0, 2'd0, 2'd3, 0);
    add(4'h7, 0, 1, 1, 2'd0, 2'd3, 0);
    add(4'h7, 1, 1, 0, 2'd0, 2'd3, 0);
    add(4'h0, 0, 1, 0, 2'd0, 2'd3, 0);

    repeat (2) @(posedge clk);
    #1;
    check4(z, "reset4");
    check3(z, "reset3");
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      step4(v, $sformatf("vec%0d", i));
    end

    // Pointer wrap on a 3-requester arbiter.
    step3(3'b010, 0, 1, 2'd1, 2'd2, "wrap_g1");
    step3(3'b000, 0, 0, 2'd0, 2'd2, "wrap_rel1");
    step3(3'b101, 0, 1, 2'd2, 2'd0, "wrap_g2");
    step3(3'b101, 1, 0, 2'd0, 2'd0, "wrap_rel2");
    step3(3'b101, 0, 1, 2'd0, 2'd1, "wrap_g0");
    step3(3'b101, 1, 0, 2'd0, 2'd1, "wrap_rel0");
    step3(3'b000, 0, 0, 2'd0, 2'd1, "wrap_idle");

    // Asynchronous reset in the middle of an active grant.
    v.req = 4'h1; v.done = 0; v.mode = 0; v.e_vld = 1; v.e_gnt = 2'd0; v.e_ptr = 2'd1; v.e_to = 0;
    step4(v, "pre_rst");
    #3;
    rst = 1'b1;
    #1;
    check4(z, "rst_async4");
    check3(z, "rst_async3");
    @(posedge clk);
    #1;
    check4(z, "rst_held");
    req = '0;
    rst = 1'b0;
    v.req = 4'h0; v.e_vld = 0; v.e_gnt = 2'd0; v.e_ptr = 2'd0;
    step4(v, "post_rst_idle");
    v.req = 4'h1; v.e_vld = 1; v.e_gnt = 2'd0; v.e_ptr = 2'd1;
    step4(v, "post_rst_gnt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
